// File: rtl/pdp8_mem_arbiter_if.sv
// Requester/memory bus bundle for the PDP-8 memory arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface pdp8_mem_arbiter_if #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 12
);
  logic [NUM_CH-1:0]            ch_req;
  logic [NUM_CH-1:0]            ch_we;
  logic [NUM_CH-1:0]            ch_lock;
  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata;
  logic [NUM_CH-1:0]            ch_grant;
  logic [NUM_CH-1:0]            ch_stall;
  logic [NUM_CH-1:0]            ch_rvalid;
  logic [DATA_WIDTH-1:0]        ch_rdata;
  logic                         mem_req;
  logic                         mem_we;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic [DATA_WIDTH-1:0]        mem_wdata;
  logic [DATA_WIDTH-1:0]        mem_rdata;

  modport slave (
    input  ch_req, ch_we, ch_lock, ch_addr, ch_wdata, mem_rdata,
    output ch_grant, ch_stall, ch_rvalid, ch_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ch_req, ch_we, ch_lock, ch_addr, ch_wdata, mem_rdata,
    input  ch_grant, ch_stall, ch_rvalid, ch_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pdp8_mem_arbiter.sv
// N-channel round-robin PDP-8 memory arbiter with locked RMW and in-order read return.
// Optional macro PDP8_ARB_CH0_PRIORITY_EN: channel 0 wins in IDLE without moving rr_ptr.
module pdp8_mem_arbiter #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pdp8_mem_arbiter_if.slave    bus
);
  localparam int unsigned IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [0:0] {ST_IDLE, ST_LOCKED} state_e;

  logic [1:0]            sync_q;
  logic                  rst_s;
  state_e                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        lock_owner_q, lock_owner_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  gnt_vld;
  logic [IDW-1:0]        gnt_id;
  logic                  prio;
  int unsigned           idx;
  logic [IDW-1:0]        cand;
  logic [RD_LATENCY-1:0] pv_q;
  logic [IDW-1:0]        pid_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_CH];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_CH];

  // Asynchronous assert, synchronous release of the internal reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], 1'b1};
  end
  assign rst_s = sync_q[1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_arr[i]  = bus.ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = bus.ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      lock_owner_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_owner_q <= lock_owner_d;
      if (gnt_vld) begin
        addr_q  <= addr_arr[gnt_id];
        wdata_q <= wdata_arr[gnt_id];
      end
    end
  end

  // Arbitration and FSM next state.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_owner_d = lock_owner_q;
    gnt_vld      = 1'b0;
    gnt_id       = '0;
    prio         = 1'b0;
    idx          = 0;
    cand         = '0;
    unique case (state_q)
      ST_IDLE: begin
`ifdef PDP8_ARB_CH0_PRIORITY_EN
        if (bus.ch_req[0]) begin
          gnt_vld = 1'b1;
          gnt_id  = '0;
          prio    = 1'b1;
        end
`endif
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          idx  = (32'(rr_ptr_q) + k) % NUM_CH;
          cand = IDW'(idx);
          if (!gnt_vld && bus.ch_req[cand]) begin
            gnt_vld = 1'b1;
            gnt_id  = cand;
          end
        end
        if (gnt_vld) begin
          if (!prio) rr_ptr_d = (gnt_id == IDW'(NUM_CH - 1)) ? '0 : gnt_id + IDW'(1);
          if (bus.ch_lock[gnt_id]) begin
            state_d      = ST_LOCKED;
            lock_owner_d = gnt_id;
          end
        end
      end
      ST_LOCKED: begin
        if (bus.ch_req[lock_owner_q]) begin
          gnt_vld = 1'b1;
          gnt_id  = lock_owner_q;
          if (!bus.ch_lock[lock_owner_q]) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst_s) gnt_vld = 1'b0;
  end

  // Read-return tracking pipeline: one slot per cycle of memory latency.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      pv_q[0]  <= 1'b0;
      pid_q[0] <= '0;
    end else begin
      pv_q[0]  <= gnt_vld & ~bus.ch_we[gnt_id];
      pid_q[0] <= gnt_id;
    end
  end

  for (genvar s = 1; s < RD_LATENCY; s++) begin : g_pipe
    always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
        pv_q[s]  <= 1'b0;
        pid_q[s] <= '0;
      end else begin
        pv_q[s]  <= pv_q[s-1];
        pid_q[s] <= pid_q[s-1];
      end
    end
  end

  assign bus.ch_grant  = gnt_vld ? (NUM_CH'(1) << gnt_id) : '0;
  assign bus.ch_stall  = bus.ch_req & ~bus.ch_grant & {NUM_CH{rst_s}};
  assign bus.ch_rvalid = pv_q[RD_LATENCY-1] ? (NUM_CH'(1) << pid_q[RD_LATENCY-1]) : '0;
  assign bus.ch_rdata  = pv_q[RD_LATENCY-1] ? bus.mem_rdata : '0;
  assign bus.mem_req   = gnt_vld;
  assign bus.mem_we    = gnt_vld & bus.ch_we[gnt_id];
  assign bus.mem_addr  = gnt_vld ? addr_arr[gnt_id]  : addr_q;
  assign bus.mem_wdata = gnt_vld ? wdata_arr[gnt_id] : wdata_q;
endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// Directed bench for pdp8_mem_arbiter: a 3-channel/latency-2 instance and a 2-channel/latency-1 instance.
module tb_pdp8_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pdp8_mem_arbiter_if #(.NUM_CH(3), .ADDR_WIDTH(12), .DATA_WIDTH(12)) bus1 ();
  pdp8_mem_arbiter_if #(.NUM_CH(2), .ADDR_WIDTH(12), .DATA_WIDTH(12)) bus2 ();

  pdp8_mem_arbiter #(.NUM_CH(3), .ADDR_WIDTH(12), .DATA_WIDTH(12), .RD_LATENCY(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));
  pdp8_mem_arbiter #(.NUM_CH(2), .ADDR_WIDTH(12), .DATA_WIDTH(12), .RD_LATENCY(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2));

  // Simple memory behind dut2 with a one-cycle read.
  logic [11:0] mem2 [4096];
  logic [11:0] m2_rdata_q = '0;
  always @(posedge clk) begin
    if (bus2.mem_req) begin
      if (bus2.mem_we) mem2[bus2.mem_addr] <= bus2.mem_wdata;
      else             m2_rdata_q <= mem2[bus2.mem_addr];
    end
  end
  assign bus2.mem_rdata = m2_rdata_q;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    bus1.ch_req = '0; bus1.ch_we = '0; bus1.ch_lock = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus1.ch_req = '0; bus1.ch_we = '0; bus1.ch_lock = '0;
    bus1.ch_addr = '0; bus1.ch_wdata = '0; bus1.mem_rdata = '0;
    bus2.ch_req = '0; bus2.ch_we = '0; bus2.ch_lock = '0;
    bus2.ch_addr = '0; bus2.ch_wdata = '0;
    repeat (3) tick();
    bus1.ch_req = 3'b111;
    #1;
    n_chk++; if (bus1.ch_grant !== 3'b000) begin n_fail++; $display("FAIL rst_grant: got %b expected 000", bus1.ch_grant); end
    n_chk++; if (bus1.ch_stall !== 3'b000) begin n_fail++; $display("FAIL rst_stall: got %b expected 000", bus1.ch_stall); end
    n_chk++; if (bus1.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", bus1.mem_req); end
    n_chk++; if (bus1.mem_addr !== 12'o0000) begin n_fail++; $display("FAIL rst_mem_addr: got %o expected 0000", bus1.mem_addr); end
    n_chk++; if (bus1.ch_rvalid !== 3'b000) begin n_fail++; $display("FAIL rst_rvalid: got %b expected 000", bus1.ch_rvalid); end
    n_chk++; if (bus1.ch_rdata !== 12'o0000) begin n_fail++; $display("FAIL rst_rdata: got %o expected 0000", bus1.ch_rdata); end
    bus1.ch_req = '0;
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_single_read;
    bus1.ch_req = 3'b001; bus1.ch_we = 3'b000;
    bus1.ch_addr[0 +: 12] = 12'o0200;
    #1;
    n_chk++; if (bus1.ch_grant !== 3'b001) begin n_fail++; $display("FAIL t1_grant: got %b expected 001", bus1.ch_grant); end
    n_chk++; if (bus1.mem_req !== 1'b1 || bus1.mem_we !== 1'b0) begin n_fail++; $display("FAIL t1_mem_req_we: got %b%b expected 10", bus1.mem_req, bus1.mem_we); end
    n_chk++; if (bus1.mem_addr !== 12'o0200) begin n_fail++; $display("FAIL t1_mem_addr: got %o expected 0200", bus1.mem_addr); end
    tick();
    bus1.ch_req = 3'b000;
    #1;
    n_chk++; if (bus1.mem_req !== 1'b0) begin n_fail++; $display("FAIL t1_idle_req: got %b expected 0", bus1.mem_req); end
    n_chk++; if (bus1.mem_addr !== 12'o0200) begin n_fail++; $display("FAIL t1_addr_hold: got %o expected 0200", bus1.mem_addr); end
    n_chk++; if (bus1.ch_rvalid !== 3'b000) begin n_fail++; $display("FAIL t1_rvalid_early: got %b expected 000", bus1.ch_rvalid); end
    tick();
    bus1.mem_rdata = 12'o7777;
    #1;
    n_chk++; if (bus1.ch_rvalid !== 3'b001) begin n_fail++; $display("FAIL t1_rvalid: got %b expected 001", bus1.ch_rvalid); end
    n_chk++; if (bus1.ch_rdata !== 12'o7777) begin n_fail++; $display("FAIL t1_rdata: got %o expected 7777", bus1.ch_rdata); end
    tick();
    #1;
    n_chk++; if (bus1.ch_rvalid !== 3'b000) begin n_fail++; $display("FAIL t1_rvalid_after: got %b expected 000", bus1.ch_rvalid); end
  endtask

  task automatic test_round_robin;
    logic [2:0]  exp_g, exp_v;
    logic [11:0] exp_a;
    apply_reset();
    bus1.ch_we = 3'b000; bus1.ch_lock = 3'b000;
    for (int i = 0; i < 3; i++) bus1.ch_addr[i*12 +: 12] = 12'(12'o0100 + i);
    for (int c = 0; c < 8; c++) begin
      bus1.ch_req    = (c < 6) ? 3'b111 : 3'b000;
      bus1.mem_rdata = 12'(c * 3 + 1);
      exp_g = (c < 6) ? 3'(3'b001 << (c % 3)) : 3'b000;
      exp_v = (c >= 2) ? 3'(3'b001 << ((c - 2) % 3)) : 3'b000;
      exp_a = 12'(12'o0100 + (c % 3));
      #1;
      n_chk++; if (bus1.ch_grant !== exp_g) begin n_fail++; $display("FAIL t2_grant c%0d: got %b expected %b", c, bus1.ch_grant, exp_g); end
      n_chk++; if (bus1.ch_stall !== (bus1.ch_req & ~exp_g)) begin n_fail++; $display("FAIL t2_stall c%0d: got %b expected %b", c, bus1.ch_stall, bus1.ch_req & ~exp_g); end
      n_chk++; if (bus1.ch_rvalid !== exp_v) begin n_fail++; $display("FAIL t2_rvalid c%0d: got %b expected %b", c, bus1.ch_rvalid, exp_v); end
      if (c < 6) begin
        n_chk++; if (bus1.mem_addr !== exp_a) begin n_fail++; $display("FAIL t2_addr c%0d: got %o expected %o", c, bus1.mem_addr, exp_a); end
      end
      if (c >= 2) begin
        n_chk++; if (bus1.ch_rdata !== 12'(c * 3 + 1)) begin n_fail++; $display("FAIL t2_rdata c%0d: got %o expected %o", c, bus1.ch_rdata, 12'(c * 3 + 1)); end
      end
      tick();
    end
  endtask

  task automatic test_locked_rmw;
    // rr_ptr is 0 here; one ch0 read moves it to 1 so ch1 wins next.
    bus1.ch_req = 3'b001; bus1.ch_we = 3'b000; bus1.ch_lock = 3'b000;
    #1;
    n_chk++; if (bus1.ch_grant !== 3'b001) begin n_fail++; $display("FAIL t3_setup: got %b expected 001", bus1.ch_grant); end
    tick();
    bus1.ch_req = 3'b000;
    repeat (3) tick();
    bus1.ch_req = 3'b111; bus1.ch_lock = 3'b010;
    bus1.ch_addr[12 +: 12] = 12'o0050;
    #1;
    n_chk++; if (bus1.ch_grant !== 3'b010) begin n_fail++; $display("FAIL t3_lock_grant: got %b expected 010", bus1.ch_grant); end
    n_chk++; if (bus1.ch_stall !== 3'b101) begin n_fail++; $display("FAIL t3_lock_stall: got %b expected 101", bus1.ch_stall); end
    n_chk++; if (bus1.mem_addr !== 12'o0050) begin n_fail++; $display("FAIL t3_lock_addr: got %o expected 0050", bus1.mem_addr); end
    tick();
    bus1.ch_req = 3'b101; bus1.ch_lock = 3'b000;
    #1;
    n_chk++; if (bus1.ch_grant !== 3'b000 || bus1.mem_req !== 1'b0) begin n_fail++; $display("FAIL t3_hold_lock: got %b/%b expected 000/0", bus1.ch_grant, bus1.mem_req); end
    n_chk++; if (bus1.ch_stall !== 3'b101) begin n_fail++; $display("FAIL t3_hold_stall: got %b expected 101", bus1.ch_stall); end
    tick();
    bus1.ch_req = 3'b111; bus1.ch_we = 3'b010;
    bus1.ch_wdata[12 +: 12] = 12'o0051;
    bus1.mem_rdata = 12'o1357;
    #1;
    n_chk++; if (bus1.ch_grant !== 3'b010) begin n_fail++; $display("FAIL t3_wr_grant: got %b expected 010", bus1.ch_grant); end
    n_chk++; if (bus1.mem_we !== 1'b1 || bus1.mem_wdata !== 12'o0051 || bus1.mem_addr !== 12'o0050) begin n_fail++; $display("FAIL t3_wr_bus: got we=%b d=%o a=%o expected we=1 d=0051 a=0050", bus1.mem_we, bus1.mem_wdata, bus1.mem_addr); end
    n_chk++; if (bus1.ch_rvalid !== 3'b010 || bus1.ch_rdata !== 12'o1357) begin n_fail++; $display("FAIL t3_rd_ret: got %b/%o expected 010/1357", bus1.ch_rvalid, bus1.ch_rdata); end
    tick();
    bus1.ch_req = 3'b101; bus1.ch_we = 3'b000;
    #1;
    n_chk++; if (bus1.ch_grant !== 3'b100) begin n_fail++; $display("FAIL t3_after_unlock: got %b expected 100", bus1.ch_grant); end
    n_chk++; if (bus1.ch_rvalid !== 3'b000) begin n_fail++; $display("FAIL t3_wr_no_rvalid: got %b expected 000", bus1.ch_rvalid); end
    tick();
    bus1.ch_req = 3'b000;
    repeat (3) tick();
  endtask

  task automatic test_reset_inflight;
    bus1.ch_req = 3'b111; bus1.ch_we = 3'b000; bus1.ch_lock = 3'b000;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    n_chk++; if (bus1.mem_req !== 1'b0 || bus1.ch_grant !== 3'b000) begin n_fail++; $display("FAIL t4_req_in_rst: got %b/%b expected 0/000", bus1.mem_req, bus1.ch_grant); end
    n_chk++; if (bus1.ch_rvalid !== 3'b000) begin n_fail++; $display("FAIL t4_rvalid_in_rst: got %b expected 000", bus1.ch_rvalid); end
    tick();
    tick();
    bus1.ch_req = 3'b000;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_chk++; if (bus1.ch_rvalid !== 3'b000) begin n_fail++; $display("FAIL t4_rvalid_post c%0d: got %b expected 000", c, bus1.ch_rvalid); end
    end
  endtask

  task automatic test_ch0_priority;
    logic [2:0] exp_c;
`ifdef PDP8_ARB_CH0_PRIORITY_EN
    exp_c = 3'b100;
`else
    exp_c = 3'b010;
`endif
    bus1.ch_we = 3'b111; bus1.ch_lock = 3'b000;
    bus1.ch_req = 3'b010;
    #1;
    n_chk++; if (bus1.ch_grant !== 3'b010) begin n_fail++; $display("FAIL t5_step_a: got %b expected 010", bus1.ch_grant); end
    tick();
    bus1.ch_req = 3'b011;
    #1;
    n_chk++; if (bus1.ch_grant !== 3'b001) begin n_fail++; $display("FAIL t5_step_b: got %b expected 001", bus1.ch_grant); end
    tick();
    bus1.ch_req = 3'b110;
    #1;
    n_chk++; if (bus1.ch_grant !== exp_c) begin n_fail++; $display("FAIL t5_step_c: got %b expected %b", bus1.ch_grant, exp_c); end
    tick();
`ifndef PDP8_ARB_CH0_PRIORITY_EN
    // Pure round-robin: ch0 grant moves rr_ptr to 1, so ch1 then beats ch0.
    bus1.ch_req = 3'b001;
    tick();
    bus1.ch_req = 3'b011;
    #1;
    n_chk++; if (bus1.ch_grant !== 3'b010) begin n_fail++; $display("FAIL t5_rr1: got %b expected 010", bus1.ch_grant); end
    tick();
`endif
    bus1.ch_req = 3'b000;
    tick();
  endtask

  task automatic test_two_ch_raw;
    bus2.ch_lock = 2'b00;
    bus2.ch_req = 2'b01; bus2.ch_we = 2'b01;
    bus2.ch_addr[0 +: 12] = 12'o0300; bus2.ch_wdata[0 +: 12] = 12'o1234;
    #1;
    n_chk++; if (bus2.ch_grant !== 2'b01 || bus2.mem_we !== 1'b1 || bus2.mem_wdata !== 12'o1234) begin n_fail++; $display("FAIL t6_wr0: got g=%b we=%b d=%o expected g=01 we=1 d=1234", bus2.ch_grant, bus2.mem_we, bus2.mem_wdata); end
    tick();
    bus2.ch_req = 2'b10; bus2.ch_we = 2'b00;
    bus2.ch_addr[12 +: 12] = 12'o0300;
    #1;
    n_chk++; if (bus2.ch_grant !== 2'b10 || bus2.mem_we !== 1'b0 || bus2.mem_addr !== 12'o0300) begin n_fail++; $display("FAIL t6_rd1: got g=%b we=%b a=%o expected g=10 we=0 a=0300", bus2.ch_grant, bus2.mem_we, bus2.mem_addr); end
    n_chk++; if (bus2.ch_rvalid !== 2'b00) begin n_fail++; $display("FAIL t6_wr_no_rvalid: got %b expected 00", bus2.ch_rvalid); end
    tick();
    bus2.ch_req = 2'b10; bus2.ch_we = 2'b10;
    bus2.ch_addr[12 +: 12] = 12'o0301; bus2.ch_wdata[12 +: 12] = 12'o4321;
    #1;
    n_chk++; if (bus2.ch_rvalid !== 2'b10 || bus2.ch_rdata !== 12'o1234) begin n_fail++; $display("FAIL t6_ret1: got %b/%o expected 10/1234", bus2.ch_rvalid, bus2.ch_rdata); end
    n_chk++; if (bus2.ch_grant !== 2'b10 || bus2.mem_we !== 1'b1) begin n_fail++; $display("FAIL t6_wr1: got g=%b we=%b expected g=10 we=1", bus2.ch_grant, bus2.mem_we); end
    tick();
    bus2.ch_req = 2'b01; bus2.ch_we = 2'b00;
    bus2.ch_addr[0 +: 12] = 12'o0301;
    #1;
    n_chk++; if (bus2.ch_grant !== 2'b01 || bus2.ch_rvalid !== 2'b00) begin n_fail++; $display("FAIL t6_rd0: got g=%b v=%b expected g=01 v=00", bus2.ch_grant, bus2.ch_rvalid); end
    tick();
    bus2.ch_req = 2'b00;
    #1;
    n_chk++; if (bus2.ch_rvalid !== 2'b01 || bus2.ch_rdata !== 12'o4321) begin n_fail++; $display("FAIL t6_ret0: got %b/%o expected 01/4321", bus2.ch_rvalid, bus2.ch_rdata); end
    n_chk++; if (bus2.mem_req !== 1'b0) begin n_fail++; $display("FAIL t6_idle: got %b expected 0", bus2.mem_req); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_locked_rmw();
    test_reset_inflight();
    test_ch0_priority();
    test_two_ch_raw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pdp8_mem_arbiter.md
Name: pdp8_mem_arbiter

Overview:
- Parametrised N-channel arbiter that multiplexes PDP-8 memory requesters onto a single shared memory port.
- Requesters include instruction fetch, exec read and exec write.
- Successor to the fixed two-port exec read/write scheme: generalised channel count, configurable read latency, and a locked read-modify-write mode for ISZ/DCA-style sequences.
- Sits between the fetch/exec units and the memory model; drives a per-channel stall.

Parameters:
- NUM_CH, 3: number of requesting channels (2..8).
- ADDR_WIDTH, 12: memory address width.
- DATA_WIDTH, 12: memory data width.
- RD_LATENCY, 2: cycles from memory read issue to mem_rdata valid (1..4).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ch_req  in  NUM_CH  per-channel request, held until granted.
- ch_we  in  NUM_CH  1 = write, 0 = read.
- ch_lock  in  NUM_CH  hold arbitration on this channel after this access.
- ch_addr  in  NUM_CH*ADDR_WIDTH  flattened addresses; channel i at [i*AW +: AW].
- ch_wdata  in  NUM_CH*DATA_WIDTH  flattened write data.
- ch_grant  out  NUM_CH  one-hot; request accepted this cycle.
- ch_stall  out  NUM_CH  ch_req[i] & ~ch_grant[i], combinational.
- ch_rvalid  out  NUM_CH  one-hot; read data for channel i valid this cycle.
- ch_rdata  out  DATA_WIDTH  read return data, shared across channels.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after a read issue.

Behaviour:
- Reset (async assert, sync deassert internally):
  - All outputs 0.
  - Round-robin pointer rr_ptr = 0.
  - FSM state = IDLE; lock_owner = 0.
  - Read-tracking pipeline cleared.
- Grants: combinational, at most one per cycle. The granted channel's access drives mem_req/mem_we/mem_addr/mem_wdata in the same cycle; the memory always accepts.
- FSM IDLE:
  - Grant the first requesting channel at or after rr_ptr, searching upward and wrapping at NUM_CH-1 -> 0.
  - On grant to channel g: rr_ptr <= (g+1) mod NUM_CH.
  - If ch_lock[g] = 1 on that grant: next state LOCKED, lock_owner <= g.
- FSM LOCKED:
  - Only lock_owner may be granted; all other requests stall.
  - A granted access with ch_lock = 0 returns the FSM to IDLE.
  - If lock_owner drops ch_req while LOCKED, remain LOCKED; there is no timeout.
  - rr_ptr does not advance while LOCKED.
- Read return:
  - Each read grant pushes {valid, channel id} into a RD_LATENCY-deep shift pipeline.
  - At pipeline exit: ch_rvalid[id] = 1 and ch_rdata = mem_rdata. Pure pass-through, no extra register.
  - Back-to-back reads from any channels, one per cycle, are supported; returns stay in order.
  - Writes produce no rvalid.
- No requests: mem_req = 0; mem_addr and mem_wdata hold their last granted values.
- Simultaneous events: grant and read return in the same cycle are independent. A channel may have rvalid and grant asserted together.
- Reset mid-operation: in-flight reads are discarded with no rvalid, and LOCKED is abandoned.
- Width rules:
  - Address and data pass unmodified; no arithmetic.
  - Channel id width is clog2(NUM_CH), minimum 1.

Optional Feature:
- Macro: PDP8_ARB_CH0_PRIORITY_EN.
- Defined:
  - In IDLE, channel 0 (exec) wins whenever ch_req[0] = 1, regardless of rr_ptr.
  - Granting channel 0 under priority does not advance rr_ptr; round-robin among channels 1..NUM_CH-1 is unchanged.
  - LOCKED behaviour is unchanged: priority never breaks a lock.
- Undefined: pure round-robin as described in Behaviour.

Test Plan:
1. Reset then idle, NUM_CH = 3: all outputs 0 → first read, ch0 addr 12'o0200, granted in the same cycle with mem_addr = 12'o0200. With mem_rdata = 12'o7777, ch_rvalid = 3'b001 and ch_rdata = 12'o7777 exactly 2 cycles later.
2. All three channels request reads continuously → grants rotate 001, 010, 100, 001. rvalid follows each grant 2 cycles later in the same order. Stalled channels see ch_stall = 1.
3. Locked RMW: ch1 reads 12'o0050 with lock = 1, while ch0 and ch2 request → ch0/ch2 stall. ch1 then writes 12'o0051 to 12'o0050 with lock = 0 next cycle → mem_we = 1; FSM returns to IDLE; ch2 is granted next (rr_ptr = 2).
4. Assert reset_n = 0 with 2 reads in flight → no ch_rvalid after reset release; mem_req = 0 immediately on assertion.
5. With PDP8_ARB_CH0_PRIORITY_EN, rr_ptr = 1, ch0 and ch1 requesting → ch0 granted first and rr_ptr remains 1. Without the macro, ch1 is granted first.
6. NUM_CH = 2, RD_LATENCY = 1: alternating write/read on ch0 and ch1 → a write followed by a read to the same address returns the written data 1 cycle after the read grant.
